lcd_cmd_scheduler: RTL and testbench
====================================

Name: lcd_cmd_scheduler

Overview:
- Shares the single command port of the 8x8 image display controller between two requesters (host CPU and script engine).
- Queues accepted commands in a shared FIFO and issues them one at a time using the controller's cmd/cmd_valid/busy handshake.
- Tracks the image-load boot phase and Write completion.
- Reports status: error pulses, issued-command count, FIFO level.

Parameters:
- FIFO_DEPTH, 4, shared command FIFO entries; power of two, minimum 2.
- ISSUE_GAP, 1, cycles held after cmd_valid before lcd_busy is sampled; range 1..7.
- CNT_W, 16, width of issued_cnt.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 command valid
- req0_cmd  in  4  requester 0 command code
- req0_ready  out  1  requester 0 accepted this cycle when high together with req0_valid
- req1_valid  in  1  requester 1 command valid
- req1_cmd  in  4  requester 1 command code
- req1_ready  out  1  requester 1 accepted this cycle when high together with req1_valid
- lcd_cmd  out  4  command to display controller
- lcd_cmd_valid  out  1  one-cycle issue strobe
- lcd_busy  in  1  display controller busy
- lcd_done  in  1  display controller frame-write done
- wr_done  out  1  one-cycle pulse on Write completion
- cmd_err  out  1  one-cycle pulse on an illegal code
- issued_cnt  out  CNT_W  commands issued since reset; wraps
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- idle  out  1  FSM in IDLE and FIFO empty

Behaviour:
- Clocking and reset: clk is the clock; reset is asynchronous, active-high.
- Reset values: all outputs 0; FIFO empty; RR pointer = requester 0; FSM = BOOT.
- Reset asserted mid-operation: any in-flight command is abandoned; lcd_cmd_valid drops immediately.

Command codes:
- Legal codes 0..11:
  - 0 Write; 1 ShiftUp; 2 ShiftDown; 3 ShiftLeft; 4 ShiftRight; 5 Max; 6 Min
  - 7 Average; 8 CCW; 9 CW; 10 MirrorX; 11 MirrorY
- Codes 12..15 are illegal. The handshake still completes (ready high), but the entry is dropped, not enqueued, and cmd_err pulses the next cycle.

Arbitration:
- Combinational ready; ready only when FIFO count < FIFO_DEPTH, using the registered count.
- A pop in the same cycle does not free space for a push while full.
- One valid requester: it is granted.
- Both valid: the RR pointer requester is granted, and the pointer moves to the other requester after each grant.
- The non-granted requester's ready is 0.
- At most one push per cycle.

FSM:
- BOOT:
  - Waits for lcd_busy to be sampled 1, then 0; this covers the image load after reset.
  - Then goes to IDLE.
  - Requests are accepted into the FIFO during BOOT.
- IDLE:
  - If FIFO is non-empty and lcd_busy=0: pop the head, register lcd_cmd = head, set lcd_cmd_valid=1, go to ISSUE.
  - lcd_cmd_valid rises the cycle after the pop decision.
  - Otherwise stay in IDLE.
- ISSUE:
  - lcd_cmd_valid is high for exactly 1 cycle.
  - issued_cnt increments on that cycle.
  - Go to HOLD.
- HOLD:
  - Count ISSUE_GAP cycles, then go to WAIT.
- WAIT:
  - If the issued code was 0 (Write): go to WAIT_DONE.
  - Otherwise, when lcd_busy=0: go to IDLE.
- WAIT_DONE:
  - On lcd_done rising edge (registered edge detect), pulse wr_done and go to IDLE.

Timing and counters:
- Minimum issue spacing = 2 + ISSUE_GAP + 1 cycles.
- lcd_cmd holds its last value between issues.
- issued_cnt wraps from 2^CNT_W-1 to 0.
- fifo_level updates each cycle: +1 on push, -1 on pop, unchanged on simultaneous push and pop.

Decomposition:
- Package lcd_pkg holds:
  - the command-code constants (CMD_WRITE..CMD_MIRROR_Y, CMD_LAST_LEGAL=11);
  - the FSM state enum (BOOT, IDLE, ISSUE, HOLD, WAIT, WAIT_DONE);
  - the function is_legal_cmd.
- Sub-module: lcd_cmd_fifo (synchronous FIFO with push/pop, count, full/empty).
- Arbiter and FSM stay in the top level.

Test Plan:
- Boot:
  - Stimulus: hold lcd_busy=1 for 64 cycles after reset release; push req0 code 1 at cycle 5.
  - Required: code enqueued (fifo_level=1); lcd_cmd_valid stays low until lcd_busy falls; then lcd_cmd=1 and valid pulses 1 cycle; issued_cnt=1.
- Round-robin:
  - Stimulus: req0 and req1 both valid every cycle, codes 5 and 6, FIFO empty, lcd_busy=0.
  - Required: grants alternate 0,1,0,1; issued sequence 5,6,5,6.
- Full FIFO:
  - Stimulus: fill with 4 commands while lcd_busy=1, then push a 5th.
  - Required: ready=0 and fifo_level=4.
  - Stimulus: release busy.
  - Required: the pop occurs; ready returns only the cycle after count drops to 3.
- Illegal code:
  - Stimulus: req1 code 13.
  - Required: ready=1; cmd_err pulses 1 cycle; fifo_level unchanged; nothing issued.
- Write completion:
  - Stimulus: issue code 0; lcd_done rises 70 cycles later.
  - Required: no further issue before done; wr_done pulses exactly once; FSM returns to IDLE.
- Mid-operation reset:
  - Stimulus: assert reset while in WAIT with 3 entries queued.
  - Required: outputs 0 asynchronously; fifo_level=0; FSM=BOOT; issued_cnt=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD command scheduler:
//   - command codes understood by the 8x8 image display controller
//   - scheduler FSM state encoding
//   - is_legal_cmd(): true for codes the controller implements
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [3:0] CMD_WRITE       = 4'd0;
    localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
    localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
    localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
    localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
    localparam logic [3:0] CMD_MAX         = 4'd5;
    localparam logic [3:0] CMD_MIN         = 4'd6;
    localparam logic [3:0] CMD_AVERAGE     = 4'd7;
    localparam logic [3:0] CMD_CCW         = 4'd8;
    localparam logic [3:0] CMD_CW          = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;
    localparam logic [3:0] CMD_LAST_LEGAL  = 4'd11;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        ISSUE,
        HOLD,
        WAIT,
        WAIT_DONE
    } sched_state_t;

    function automatic logic is_legal_cmd(input logic [3:0] code);
        return (code <= CMD_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// ---------------------------------------------------------------------------
// lcd_cmd_fifo
// Synchronous FIFO holding pending display commands (first-word fall-through:
// dout always shows the head entry).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, din       write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   dout            head entry
//   count           current occupancy (0..DEPTH)
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_cmd_scheduler
// Shares the display controller's single command port between two requesters.
// Accepted commands go through a round-robin arbiter into a shared FIFO and
// are issued one at a time over the cmd/cmd_valid/busy handshake.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   req0_valid/req0_cmd/req0_ready   requester 0 (host CPU) command channel
//   req1_valid/req1_cmd/req1_ready   requester 1 (script engine) channel
//   lcd_cmd, lcd_cmd_valid           command and one-cycle issue strobe
//   lcd_busy, lcd_done               controller busy and frame-write done
//   wr_done                          pulse when a Write has completed
//   cmd_err                          pulse one cycle after an illegal code
//   issued_cnt                       commands issued since reset (wraps)
//   fifo_level                       FIFO occupancy
//   idle                             FSM in IDLE with nothing queued
// ---------------------------------------------------------------------------
module lcd_cmd_scheduler
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 1,
    parameter int CNT_W      = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [3:0]       req0_cmd,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_cmd,
    output logic             req1_ready,
    output logic [3:0]       lcd_cmd,
    output logic             lcd_cmd_valid,
    input  logic             lcd_busy,
    input  logic             lcd_done,
    output logic             wr_done,
    output logic             cmd_err,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [LVL_W-1:0] fifo_level,
    output logic             idle
);

    sched_state_t state;
    logic         rr_ptr;
    logic         space;
    logic         take0;
    logic         take1;
    logic         accept;
    logic [3:0]   sel_cmd;
    logic         push;
    logic         pop;
    logic [3:0]   fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    logic [2:0]   gap_cnt;
    logic         busy_seen;
    logic         last_write;
    logic         done_q;

    // Space is judged on the registered count only, so a pop in the same
    // cycle never opens room for a push. Ready is forced low during reset.
    assign space      = !reset && (fifo_level < LVL_W'(FIFO_DEPTH));
    assign req0_ready = space && (!req1_valid || !rr_ptr);
    assign req1_ready = space && (!req0_valid || rr_ptr);
    assign take0      = req0_valid && req0_ready;
    assign take1      = req1_valid && req1_ready;
    assign accept     = take0 || take1;
    assign sel_cmd    = take1 ? req1_cmd : req0_cmd;
    assign push       = accept && is_legal_cmd(sel_cmd);
    assign pop        = (state == IDLE) && !fifo_empty && !lcd_busy;
    assign idle       = (state == IDLE) && fifo_empty;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (4)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (sel_cmd),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The pointer always moves away from whoever was just granted; illegal
    // codes still complete the handshake, so they also move it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            if (take0) begin
                rr_ptr <= 1'b1;
            end else if (take1) begin
                rr_ptr <= 1'b0;
            end
            cmd_err <= accept && !is_legal_cmd(sel_cmd);
        end
    end

    // Issue FSM. BOOT sits out the controller's image load (busy seen high,
    // then low). After each issue, HOLD gives the controller ISSUE_GAP cycles
    // to raise busy before WAIT looks at it; a Write instead waits for the
    // rising edge of lcd_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= BOOT;
            lcd_cmd       <= '0;
            lcd_cmd_valid <= 1'b0;
            issued_cnt    <= '0;
            gap_cnt       <= '0;
            busy_seen     <= 1'b0;
            last_write    <= 1'b0;
            done_q        <= 1'b0;
            wr_done       <= 1'b0;
        end else begin
            lcd_cmd_valid <= 1'b0;
            wr_done       <= 1'b0;
            done_q        <= lcd_done;
            case (state)
                BOOT: begin
                    if (busy_seen && !lcd_busy) begin
                        state <= IDLE;
                    end else if (lcd_busy) begin
                        busy_seen <= 1'b1;
                    end
                end
                IDLE: begin
                    if (pop) begin
                        lcd_cmd       <= fifo_head;
                        lcd_cmd_valid <= 1'b1;
                        issued_cnt    <= issued_cnt + CNT_W'(1);
                        last_write    <= (fifo_head == CMD_WRITE);
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    gap_cnt <= '0;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (gap_cnt == 3'(ISSUE_GAP - 1)) begin
                        state <= WAIT;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end
                WAIT: begin
                    if (last_write) begin
                        state <= WAIT_DONE;
                    end else if (!lcd_busy) begin
                        state <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (lcd_done && !done_q) begin
                        wr_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_scheduler
// Self-checking bench for lcd_cmd_scheduler. Stimulus pushes the expected
// issue order into exp_q; a negedge monitor pops and compares every issued
// command and counts wr_done pulses.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_scheduler;

    localparam int FIFO_DEPTH = 4;
    localparam int ISSUE_GAP  = 1;
    localparam int CNT_W      = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid;
    logic [3:0]       req0_cmd;
    logic             req0_ready;
    logic             req1_valid;
    logic [3:0]       req1_cmd;
    logic             req1_ready;
    logic [3:0]       lcd_cmd;
    logic             lcd_cmd_valid;
    logic             lcd_busy;
    logic             lcd_done;
    logic             wr_done;
    logic             cmd_err;
    logic [CNT_W-1:0] issued_cnt;
    logic [LVL_W-1:0] fifo_level;
    logic             idle;

    int         checks      = 0;
    int         errors      = 0;
    int         issue_count = 0;
    int         wr_pulses   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] fill_codes [4] = '{4'd2, 4'd3, 4'd4, 4'd7};
    logic [3:0] held_codes [3] = '{4'd1, 4'd2, 4'd3};

    always #5 clk = ~clk;

    lcd_cmd_scheduler #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ISSUE_GAP  (ISSUE_GAP),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_cmd      (req0_cmd),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_cmd      (req1_cmd),
        .req1_ready    (req1_ready),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .lcd_busy      (lcd_busy),
        .lcd_done      (lcd_done),
        .wr_done       (wr_done),
        .cmd_err       (cmd_err),
        .issued_cnt    (issued_cnt),
        .fifo_level    (fifo_level),
        .idle          (idle)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v0, input logic [3:0] c0,
                                  input logic v1, input logic [3:0] c1);
        req0_valid = v0;
        req0_cmd   = c0;
        req1_valid = v1;
        req1_cmd   = c1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issues(input int target, input int budget);
        int n = 0;
        while (issue_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_output("issue_wait", issue_count, target);
    endtask

    // Monitor: every issue strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && lcd_cmd_valid) begin
            issue_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_issue actual=%0d expected=none", lcd_cmd);
            end else begin
                check_output("issued_cmd", lcd_cmd, exp_q.pop_front());
            end
        end
        if (!reset && wr_done) begin
            wr_pulses++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        lcd_busy = 1'b0;
        lcd_done = 1'b0;
        apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
        repeat (3) step();

        // Reset state
        check_output("rst_valid", lcd_cmd_valid, 0);
        check_output("rst_cmd", lcd_cmd, 0);
        check_output("rst_cnt", issued_cnt, 0);
        check_output("rst_level", fifo_level, 0);
        check_output("rst_err", cmd_err, 0);
        check_output("rst_wr_done", wr_done, 0);
        check_output("rst_idle", idle, 0);
        check_output("rst_ready0", req0_ready, 0);

        // Boot: busy held for 64 cycles, a command queued at cycle 5
        lcd_busy = 1'b1;
        reset    = 1'b0;
        repeat (5) step();
        apply_stimulus(1'b1, 4'd1, 1'b0, 4'd0);
        #1;
        check_output("boot_ready0", req0_ready, 1);
        exp_q.push_back(4'd1);
        step();
        apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
        check_output("boot_level", fifo_level, 1);
        repeat (58) step();
        check_output("boot_no_issue", issue_count, 0);
        check_output("boot_level_held", fifo_level, 1);
        lcd_busy = 1'b0;
        wait_issues(1, 20);
        #1;
        check_output("boot_cnt", issued_cnt, 1);
        repeat (3) step();
        check_output("boot_single_strobe", issue_count, 1);
        check_output("boot_cmd_held", lcd_cmd, 1);

        // Illegal code on requester 1
        step();
        apply_stimulus(1'b0, 4'd0, 1'b1, 4'd13);
        #1;
        check_output("illegal_ready1", req1_ready, 1);
        step();
        apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
        check_output("illegal_err_hi", cmd_err, 1);
        check_output("illegal_level", fifo_level, 0);
        step();
        check_output("illegal_err_lo", cmd_err, 0);
        repeat (5) step();
        check_output("illegal_no_issue", issue_count, 1);

        // Round-robin: pointer now at requester 0
        for (int i = 0; i < 4; i++) begin
            step();
            apply_stimulus(1'b1, 4'd5, 1'b1, 4'd6);
            #1;
            check_output("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check_output("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
            exp_q.push_back((i % 2 == 0) ? 4'd5 : 4'd6);
        end
        step();
        apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
        wait_issues(5, 60);
        #1;
        repeat (4) step();
        check_output("rr_idle", idle, 1);

        // Full FIFO
        lcd_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, fill_codes[i], 1'b0, 4'd0);
            #1;
            check_output("fill_ready0", req0_ready, 1);
            exp_q.push_back(fill_codes[i]);
            step();
        end
        apply_stimulus(1'b1, 4'd8, 1'b0, 4'd0);
        #1;
        check_output("full_ready0", req0_ready, 0);
        check_output("full_level", fifo_level, 4);
        lcd_busy = 1'b0;
        step();
        check_output("pop_level", fifo_level, 3);
        check_output("pop_ready0", req0_ready, 1);
        exp_q.push_back(4'd8);
        step();
        apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
        check_output("refill_level", fifo_level, 4);
        wait_issues(10, 100);
        #1;
        check_output("full_cnt", issued_cnt, 10);

        // Write completion
        repeat (5) step();
        check_output("write_idle", idle, 1);
        apply_stimulus(1'b1, 4'd0, 1'b0, 4'd0);
        #1;
        check_output("write_ready0", req0_ready, 1);
        exp_q.push_back(4'd0);
        step();
        apply_stimulus(1'b1, 4'd9, 1'b0, 4'd0);
        exp_q.push_back(4'd9);
        step();
        apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
        wait_issues(11, 20);
        #1;
        repeat (70) step();
        check_output("write_blocked", issue_count, 11);
        check_output("write_no_early_done", wr_pulses, 0);
        check_output("write_level", fifo_level, 1);
        lcd_done = 1'b1;
        repeat (3) step();
        lcd_done = 1'b0;
        repeat (2) step();
        check_output("write_done_once", wr_pulses, 1);
        wait_issues(12, 20);
        #1;
        check_output("write_cnt", issued_cnt, 12);
        check_output("write_cmd", lcd_cmd, 9);

        // Mid-operation reset while stuck in WAIT with 3 queued
        repeat (5) step();
        apply_stimulus(1'b1, 4'd10, 1'b0, 4'd0);
        exp_q.push_back(4'd10);
        step();
        apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
        wait_issues(13, 20);
        #1;
        lcd_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, held_codes[i], 1'b0, 4'd0);
            step();
        end
        apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
        check_output("held_level", fifo_level, 3);
        #3;
        reset = 1'b1;
        #1;
        check_output("midrst_valid", lcd_cmd_valid, 0);
        check_output("midrst_level", fifo_level, 0);
        check_output("midrst_cnt", issued_cnt, 0);
        check_output("midrst_cmd", lcd_cmd, 0);
        check_output("midrst_idle", idle, 0);
        step();
        reset    = 1'b0;
        lcd_busy = 1'b0;
        apply_stimulus(1'b1, 4'd4, 1'b0, 4'd0);
        exp_q.push_back(4'd4);
        step();
        apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
        repeat (10) step();
        check_output("reboot_no_issue", issue_count, 13);
        check_output("reboot_level", fifo_level, 1);
        lcd_busy = 1'b1;
        repeat (2) step();
        lcd_busy = 1'b0;
        wait_issues(14, 20);
        #1;
        check_output("reboot_cnt", issued_cnt, 1);
        check_output("reboot_cmd", lcd_cmd, 4);

        repeat (5) step();
        check_output("scoreboard_drained", exp_q.size(), 0);
        check_output("final_idle", idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
